// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer and for users of the
// interrupt controller: SPR index map, sequencer state encoding, cause count,
// default ISR entry address and continue-type level mask.
package exception_pkg;

  localparam int NUM_CAUSES = 23;

  localparam logic [2:0] SPR_SR    = 3'd0;
  localparam logic [2:0] SPR_ESR   = 3'd1;
  localparam logic [2:0] SPR_ECA   = 3'd2;
  localparam logic [2:0] SPR_EPC   = 3'd3;
  localparam logic [2:0] SPR_EDATA = 3'd4;

  localparam logic [31:0]           DEFAULT_SISR      = 32'h0000_0000;
  localparam logic [NUM_CAUSES-1:0] DEFAULT_CONT_MASK = 23'h7E_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // True when level il is continue-type. The mask is zero-extended to 32 bits
  // so illegal levels (il >= NUM_CAUSES) fall out as repeat-type.
  function automatic logic is_continue(input logic [4:0]            il,
                                       input logic [NUM_CAUSES-1:0] mask);
    logic [31:0] wide;
    wide = {{(32-NUM_CAUSES){1'b0}}, mask};
    return wide[il];
  endfunction

endpackage

// File: rtl/exception_sequencer_spr_file.sv
// Special-purpose register storage (SR, ESR, ECA, EPC and optionally EDATA),
// combinational read mux and write-enable qualification.
// Optional feature macro: EDATA_CAPTURE_EN (adds the EDATA register at index 4).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   idle              sequencer is in IDLE
//   snap              jump-to-ISR accepted this cycle (snapshot state)
//   restore           eret accepted this cycle (SR <= ESR)
//   ca, epc_snap, ea  values captured on snap
//   spr_we/addr/wdata datapath write port
//   spr_rdata         combinational read data
//   sr, esr, epc      register values used by the sequencer
module spr_file
  import exception_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idle,
  input  logic                  snap,
  input  logic                  restore,
  input  logic [NUM_CAUSES-1:0] ca,
  input  logic [31:0]           epc_snap,
  input  logic [31:0]           ea,
  input  logic                  spr_we,
  input  logic [2:0]            spr_addr,
  input  logic [31:0]           spr_wdata,
  output logic [31:0]           spr_rdata,
  output logic [31:0]           sr,
  output logic [31:0]           esr,
  output logic [31:0]           epc
);

  logic [31:0] eca;
  logic        write_en;

  // A jisr or eret taken in the same cycle drops the datapath write.
  assign write_en = spr_we && idle && !snap && !restore;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      esr <= '0;
      eca <= '0;
      epc <= '0;
    end else if (snap) begin
      esr <= sr;
      eca <= {{(32-NUM_CAUSES){1'b0}}, ca};
      sr  <= '0;
      epc <= epc_snap;
    end else if (restore) begin
      sr  <= esr;
    end else if (write_en) begin
      case (spr_addr)
        SPR_SR:  sr  <= spr_wdata;
        SPR_ESR: esr <= spr_wdata;
        SPR_ECA: eca <= spr_wdata;
        SPR_EPC: epc <= spr_wdata;
        default: ;
      endcase
    end
  end

`ifdef EDATA_CAPTURE_EN
  logic [31:0] edata;

  always_ff @(posedge clk) begin
    if (reset) begin
      edata <= '0;
    end else if (snap) begin
      edata <= ea;
    end else if (write_en && spr_addr == SPR_EDATA) begin
      edata <= spr_wdata;
    end
  end
`else
  // No EDATA storage; the faulting address is intentionally dropped.
  logic unused_ea;
  assign unused_ea = ^ea;
`endif

  // NOTE: every combinational output gets a default first so no latch is
  // inferred for unlisted addresses.
  always_comb begin
    spr_rdata = '0;
    case (spr_addr)
      SPR_SR:    spr_rdata = sr;
      SPR_ESR:   spr_rdata = esr;
      SPR_ECA:   spr_rdata = eca;
      SPR_EPC:   spr_rdata = epc;
`ifdef EDATA_CAPTURE_EN
      SPR_EDATA: spr_rdata = edata;
`endif
      default:   spr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: consumes jisr/il from the interrupt controller, owns
// the SPRs (via spr_file), flushes the pipeline and redirects fetch to the
// ISR entry on jisr or to EPC on eret.
// Optional feature macro: EDATA_CAPTURE_EN (EDATA capture of ea on jisr).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   jisr, il, ca, pc, pc_next, ea   exception entry inputs
//   eret                            return-from-exception commit
//   spr_we, spr_addr, spr_wdata     SPR write port; spr_rdata read data
//   sr                              status register to the interrupt controller
//   flush                           one-cycle pipeline squash
//   redirect_valid/pc/ready         fetch redirect handshake
//   busy                            sequence in progress
module exception_sequencer
  import exception_pkg::*;
#(
  parameter logic [31:0]           SISR      = DEFAULT_SISR,
  parameter logic [NUM_CAUSES-1:0] CONT_MASK = DEFAULT_CONT_MASK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  jisr,
  input  logic [4:0]            il,
  input  logic [NUM_CAUSES-1:0] ca,
  input  logic [31:0]           pc,
  input  logic [31:0]           pc_next,
  input  logic                  eret,
  input  logic [31:0]           ea,
  input  logic                  spr_we,
  input  logic [2:0]            spr_addr,
  input  logic [31:0]           spr_wdata,
  output logic [31:0]           spr_rdata,
  output logic [31:0]           sr,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready,
  output logic                  busy
);

  state_t      state;
  state_t      state_next;
  logic [31:0] target;
  logic [31:0] esr;
  logic [31:0] epc;
  logic [31:0] epc_snap;
  logic        idle;
  logic        take_jisr;
  logic        take_eret;

  // Events are only sampled in IDLE; jisr outranks a simultaneous eret.
  assign idle      = (state == IDLE);
  assign take_jisr = idle && jisr;
  assign take_eret = idle && eret && !jisr;
  assign epc_snap  = is_continue(il, CONT_MASK) ? pc_next : pc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (take_jisr || take_eret) state_next = FLUSH;
      FLUSH:    state_next = REDIRECT;
      REDIRECT: if (redirect_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decode the state register only, so they stay glitch-free and
  // hold steady through a stalled redirect.
  always_comb begin
    flush          = (state == FLUSH);
    redirect_valid = (state == REDIRECT);
    busy           = (state != IDLE);
    redirect_pc    = target;
  end

  always_ff @(posedge clk) begin
    if (reset)          target <= '0;
    else if (take_jisr) target <= SISR;
    else if (take_eret) target <= epc;
  end

  spr_file u_spr_file (
    .clk       (clk),
    .reset     (reset),
    .idle      (idle),
    .snap      (take_jisr),
    .restore   (take_eret),
    .ca        (ca),
    .epc_snap  (epc_snap),
    .ea        (ea),
    .spr_we    (spr_we),
    .spr_addr  (spr_addr),
    .spr_wdata (spr_wdata),
    .spr_rdata (spr_rdata),
    .sr        (sr),
    .esr       (esr),
    .epc       (epc)
  );

  // ESR feeds the restore path inside spr_file; the top only needs it for
  // completeness of the register view.
  logic unused_esr;
  assign unused_esr = ^esr;

endmodule

// File: tb/tb_exception_sequencer.sv
`timescale 1ns/1ps
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        jisr;
  logic [4:0]  il;
  logic [22:0] ca;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        eret;
  logic [31:0] ea;
  logic        spr_we;
  logic [2:0]  spr_addr;
  logic [31:0] spr_wdata;
  logic [31:0] spr_rdata;
  logic [31:0] sr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

`ifdef EDATA_CAPTURE_EN
  localparam bit HAS_EDATA = 1'b1;
`else
  localparam bit HAS_EDATA = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model of the SPRs.
  logic [31:0] m_sr, m_esr, m_eca, m_epc, m_edata;

  always #10 clk = ~clk;

  exception_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .jisr           (jisr),
    .il             (il),
    .ca             (ca),
    .pc             (pc),
    .pc_next        (pc_next),
    .eret           (eret),
    .ea             (ea),
    .spr_we         (spr_we),
    .spr_addr       (spr_addr),
    .spr_wdata      (spr_wdata),
    .spr_rdata      (spr_rdata),
    .sr             (sr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_sr;
      3'd1:    return m_esr;
      3'd2:    return m_eca;
      3'd3:    return m_epc;
      3'd4:    return HAS_EDATA ? m_edata : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Levels 17..22 are continue-type; everything else (incl. illegal) repeats.
  function automatic logic [31:0] m_epc_of(input logic [4:0] l, input logic [31:0] p,
                                           input logic [31:0] pn);
    return (l >= 5'd17 && l <= 5'd22) ? pn : p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    jisr = 1'b0; eret = 1'b0; spr_we = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic model_reset;
    m_sr = '0; m_esr = '0; m_eca = '0; m_epc = '0; m_edata = '0;
  endtask

  // Read every SPR index and compare idle status outputs against the model.
  task automatic verify_state(input string tag);
    for (int a = 0; a < 8; a++) begin
      spr_addr = 3'(a);
      #1;
      n_tests++;
      if (spr_rdata !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL %s spr[%0d]: got %h expected %h", tag, a, spr_rdata, m_read(3'(a)));
      end
    end
    n_tests++;
    if (sr !== m_sr || busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_out: sr=%h busy=%b flush=%b rv=%b expected sr=%h busy=0 flush=0 rv=0",
               tag, sr, busy, flush, redirect_valid, m_sr);
    end
  endtask

  // Called one cycle after an accepted event: expects flush, then a redirect
  // held for delay+1 cycles, with optional garbage on the inputs meanwhile.
  task automatic expect_seq(input string tag, input logic [31:0] tgt, input int delay,
                            input bit noise);
    if (noise) begin
      jisr = 1'($urandom); eret = 1'($urandom); spr_we = 1'($urandom);
      spr_addr = 3'($urandom); spr_wdata = $urandom; il = 5'($urandom); pc = $urandom;
    end
    n_tests++;
    if (flush !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flush_cycle: flush=%b busy=%b rv=%b expected 1 1 0",
               tag, flush, busy, redirect_valid);
    end
    tick;
    for (int d = 0; d <= delay; d++) begin
      if (noise) begin
        jisr = 1'($urandom); eret = 1'($urandom); spr_we = 1'($urandom);
        spr_addr = 3'($urandom); spr_wdata = $urandom;
      end
      n_tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== tgt || flush !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s redirect[%0d]: rv=%b pc=%h flush=%b busy=%b expected 1 %h 0 1",
                 tag, d, redirect_valid, redirect_pc, flush, busy, tgt);
      end
      redirect_ready = (d == delay);
      tick;
    end
    quiet;
    n_tests++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: busy=%b rv=%b flush=%b expected 0 0 0",
               tag, busy, redirect_valid, flush);
    end
  endtask

  // One IDLE cycle with any combination of jisr / eret / SPR write.
  task automatic fire(input string tag, input bit do_jisr, input bit do_eret, input bit do_we,
                      input logic [4:0] il_v, input logic [31:0] pc_v, input logic [31:0] pcn_v,
                      input logic [31:0] ea_v, input logic [22:0] ca_v,
                      input logic [2:0] addr_v, input logic [31:0] wd_v,
                      input int delay, input bit noise);
    logic [31:0] tgt;
    bit          taken;
    jisr = do_jisr; eret = do_eret; spr_we = do_we;
    il = il_v; pc = pc_v; pc_next = pcn_v; ea = ea_v; ca = ca_v;
    spr_addr = addr_v; spr_wdata = wd_v;
    #1;
    n_tests++;
    if (spr_rdata !== m_read(addr_v)) begin
      n_fail++;
      $display("FAIL %s no_bypass: got %h expected %h", tag, spr_rdata, m_read(addr_v));
    end
    taken = 1'b0;
    tgt   = '0;
    if (do_jisr) begin
      m_esr = m_sr; m_eca = {9'b0, ca_v}; m_sr = '0;
      m_epc = m_epc_of(il_v, pc_v, pcn_v); m_edata = ea_v;
      tgt = 32'h0; taken = 1'b1;
    end else if (do_eret) begin
      m_sr = m_esr; tgt = m_epc; taken = 1'b1;
    end else if (do_we) begin
      case (addr_v)
        3'd0: m_sr = wd_v;
        3'd1: m_esr = wd_v;
        3'd2: m_eca = wd_v;
        3'd3: m_epc = wd_v;
        3'd4: m_edata = wd_v;
        default: ;
      endcase
    end
    tick;
    quiet;
    if (taken) expect_seq(tag, tgt, delay, noise);
    verify_state(tag);
  endtask

  task automatic test_reset;
    quiet; reset = 1'b1; il = '0; ca = '0; pc = '0; pc_next = '0; ea = '0;
    spr_addr = '0; spr_wdata = '0;
    model_reset;
    repeat (3) tick;
    reset = 1'b0;
    verify_state("reset");
  endtask

  task automatic test_spr_rw;
    fire("wr_sr", 0, 0, 1, 5'd0, 0, 0, 0, 0, 3'd0, 32'h0000_FFFE, 0, 0);
    fire("wr_eca", 0, 0, 1, 5'd0, 0, 0, 0, 0, 3'd2, 32'h1234_5678, 0, 0);
    fire("wr_5", 0, 0, 1, 5'd0, 0, 0, 0, 0, 3'd5, 32'hFFFF_FFFF, 0, 0);
    fire("wr_4", 0, 0, 1, 5'd0, 0, 0, 0, 0, 3'd4, 32'hA5A5_5A5A, 0, 0);
  endtask

  task automatic test_jisr_repeat;
    fire("jisr_rep", 1, 0, 0, 5'd1, 32'h100, 32'h104, 32'h0, 23'h2, 3'd1, 0, 0, 0);
  endtask

  task automatic test_eret;
    fire("eret", 0, 1, 0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 2, 0);
  endtask

  task automatic test_jisr_continue_stall;
    fire("jisr_cont", 1, 0, 0, 5'd17, 32'h200, 32'h204, 32'h0, 23'h2_0000, 3'd3, 0, 5, 0);
    fire("eret2", 0, 1, 0, 5'd0, 0, 0, 0, 0, 3'd3, 0, 0, 0);
  endtask

  task automatic test_priority;
    fire("wr_sr2", 0, 0, 1, 5'd0, 0, 0, 0, 0, 3'd0, 32'h0000_0F0F, 0, 0);
    fire("jisr_eret_we", 1, 1, 1, 5'd3, 32'h300, 32'h304, 32'h0, 23'h8, 3'd0, 32'hBAD0_BAD0, 1, 0);
    fire("eret_we", 0, 1, 1, 5'd0, 0, 0, 0, 0, 3'd1, 32'hBAD1_BAD1, 0, 0);
    fire("jisr_illegal", 1, 0, 0, 5'd25, 32'h400, 32'h404, 32'h0, 23'h7F_FFFF, 3'd3, 0, 0, 0);
    fire("jisr_busy", 1, 0, 0, 5'd22, 32'h500, 32'h504, 32'h0, 23'h40_0000, 3'd3, 0, 4, 1);
  endtask

  task automatic test_edata;
    fire("edata", 1, 0, 0, 5'd2, 32'h600, 32'h604, 32'hDEAD_BEE0, 23'h4, 3'd4, 0, 0, 0);
  endtask

  task automatic test_reset_midflight;
    for (int s = 0; s < 2; s++) begin
      jisr = 1'b1; il = 5'd1; pc = 32'h700; pc_next = 32'h704; ca = 23'h1;
      tick;
      quiet;
      if (s == 1) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      model_reset;
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid[%0d,%0d]: flush=%b rv=%b busy=%b expected 0 0 0",
                   s, c, flush, redirect_valid, busy);
        end
        tick;
      end
      verify_state("reset_mid");
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: fire("rnd_nop", 0, 0, 0, 5'($urandom), $urandom, $urandom, $urandom, 23'($urandom),
                3'($urandom), $urandom, 0, 0);
        1: fire("rnd_we", 0, 0, 1, 5'($urandom), $urandom, $urandom, $urandom, 23'($urandom),
                3'($urandom), $urandom, 0, 0);
        2: fire("rnd_jisr", 1, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
                $urandom, 23'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3), 1);
        default: fire("rnd_eret", 0, 1, 1'($urandom), 5'($urandom), $urandom, $urandom,
                      $urandom, 23'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3), 1);
      endcase
    end
  endtask

  initial begin
    test_reset;
    test_spr_rw;
    test_jisr_repeat;
    test_eret;
    test_jisr_continue_stall;
    test_priority;
    test_edata;
    test_reset_midflight;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Consumer side of the interrupt controller's jisr/il output. Owns the special-purpose registers SR, ESR, ECA, EPC and EDATA, and drives sr back into the interrupt controller.
- On a jump-to-ISR it snapshots machine state, masks all interrupts, flushes the pipeline and redirects fetch to SISR.
- On eret it restores SR and redirects fetch to EPC.
- Also serves movs2g/movg2s special-purpose register accesses from the datapath.

Parameters:
- SISR, 32'h0000_0000, interrupt service routine entry address.
- CONT_MASK, 23'h7E_0000, bit i=1 means level i is continue-type (EPC<=pc_next); bit i=0 means repeat-type (EPC<=pc).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jisr  in  1  jump-to-ISR request from the interrupt controller
- il  in  5  interrupt level (lowest active masked cause index)
- ca  in  23  raw cause vector, saved into ECA
- pc  in  32  address of the interrupted instruction
- pc_next  in  32  address of the following instruction
- eret  in  1  eret instruction committing this cycle
- ea  in  32  faulting effective address (used only with EDATA_CAPTURE_EN)
- spr_we  in  1  SPR write strobe
- spr_addr  in  3  SPR index: 0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA
- spr_wdata  in  32  SPR write data
- spr_rdata  out  32  SPR read data (combinational)
- sr  out  32  status register, drives the interrupt controller mask
- flush  out  1  one-cycle pipeline squash
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Reset values: state IDLE; SR, ESR, ECA, EPC, EDATA, target all 0; flush, redirect_valid, busy all 0.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, jisr=1 at edge N:
  - ESR<=sr; ECA<={9'b0,ca}; SR<=0.
  - EPC<=(il<23 && CONT_MASK[il]) ? pc_next : pc.
  - target<=SISR; next state FLUSH.
- IDLE, eret=1 with jisr=0: SR<=ESR; target<=EPC; next state FLUSH.
- FLUSH: flush=1 for exactly one cycle (cycle N+1); then REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target, both held stable until redirect_ready=1.
  - On the handshake cycle, return to IDLE.
  - Earliest redirect_valid is cycle N+2; it stays high indefinitely while ready is low.
- busy=1 in FLUSH and REDIRECT.
- Priority:
  - jisr beats eret; a simultaneous eret is dropped and ESR captures the pre-event sr.
  - jisr or eret beats spr_we in the same cycle; the write is dropped.
- jisr and eret are ignored while busy. Cause sources hold their lines, so an unmasked cause is re-sampled in IDLE after the redirect.
- SPR writes are accepted only in IDLE. Address 4 without the feature, and addresses 5-7, read 0 and ignore writes.
- spr_rdata returns the current register value; a write lands at the next edge, with no bypass.
- il>=23 with jisr=1 is an illegal encoding and is treated as repeat-type.
- sr is a direct register output with no combinational path from inputs.
- Reset asserted in FLUSH or REDIRECT: return to IDLE next edge, with no flush or redirect emitted afterward.

Optional Feature:
- Macro: EDATA_CAPTURE_EN.
- Defined: EDATA register is present. On jisr, EDATA<=ea; spr_addr 4 reads/writes EDATA.
- Undefined: no EDATA flops; ea is unused; address 4 reads 0 and ignores writes.

Decomposition:
- Shared package exception_pkg holds:
  - SPR index constants SPR_SR..SPR_EDATA;
  - state enum (IDLE/FLUSH/REDIRECT);
  - NUM_CAUSES=23;
  - default SISR and CONT_MASK constants, shared with interrupt_controller users.
- Sub-module: spr_file (register storage plus read mux plus write-enable qualification). The FSM stays in the top.

Test Plan:
- Reset, then SPR write SR=32'h0000_FFFE; read back 32'h0000_FFFE; sr output matches; state IDLE.
- sr=32'hFFFE, jisr=1, il=1, pc=0x100, pc_next=0x104 -> ESR=0xFFFE, SR=0, EPC=0x100, flush at N+1, redirect_valid/pc=0 at N+2.
- jisr with il=17 (continue-type), pc_next=0x204 -> EPC=0x204; redirect_ready low 5 cycles -> redirect_valid held 5 cycles, single handshake.
- After ISR, eret=1 -> SR restored to 0xFFFE, redirect_pc=0x100; jisr and eret in same cycle -> jisr wins.
- jisr during REDIRECT and spr_we concurrent with jisr -> both ignored; registers unchanged except the jisr snapshot.
- With EDATA_CAPTURE_EN: jisr with ea=0xDEAD_BEE0 -> SPR 4 reads 0xDEADBEE0. Without the macro: SPR 4 reads 0.
